// File: rtl/sub32_serial_pkg.sv
// Shared definitions for the serial subtractor.
// Holds the default operand/digit widths, the FSM state encoding and a helper
// that sizes the slice counter for any WIDTH/DIGIT combination.
package sub32_serial_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned DIGIT_DEF   = 4;
    localparam int unsigned NSLICE_DEF  = WIDTH_DEF / DIGIT_DEF;
    localparam int unsigned SLICE_CNT_W = $clog2(NSLICE_DEF);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter width for a given slice count; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple subtractor: d = x - y - bi.
// Ports:
//   x  - minuend slice
//   y  - subtrahend slice
//   bi - borrow into the least significant bit
//   d  - difference slice
//   bo - borrow out of the most significant bit
module sub_digit
    import sub32_serial_pkg::*;
#(
    parameter int unsigned DIGIT = DIGIT_DEF
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic [DIGIT:0] br;

    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bi;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]      = x[i] ^ y[i] ^ br[i];
            br[i + 1] = (~x[i] & y[i]) | (~x[i] & br[i]) | (y[i] & br[i]);
        end
    end

    assign bo = br[DIGIT];

endmodule

// File: rtl/sub32_serial.sv
// Multi-cycle subtractor: diff = a - b - bin, one DIGIT-bit slice per cycle.
// Ports:
//   m_clock - clock, rising edge
//   p_reset - synchronous active-low reset
//   start   - request, accepted in IDLE or DONE
//   a, b    - minuend / subtrahend, captured on the accepting edge
//   bin     - borrow-in, captured on the accepting edge
//   busy    - high while slices are processed
//   done    - one-cycle pulse when results are committed
//   diff    - (a - b - bin) mod 2^WIDTH
//   bout    - unsigned borrow-out
//   ov      - signed overflow
//   zero    - diff == 0
// Results and flags change only on the commit edge and hold otherwise.
module sub32_serial
    import sub32_serial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIGIT = DIGIT_DEF
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ov,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / DIGIT;
    localparam int unsigned CNT_W  = cnt_width(NSLICE);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, b_sh_q, pdiff_q, diff_q;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q, a_msb_q, b_msb_q;
    logic             bout_q, ov_q, zero_q;

    logic             accept, last;
    logic [DIGIT-1:0] slice_d;
    logic             slice_bo;
    logic [WIDTH-1:0] pdiff_next;

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_sub_digit (
        .x  (a_sh_q[DIGIT-1:0]),
        .y  (b_sh_q[DIGIT-1:0]),
        .bi (borrow_q),
        .d  (slice_d),
        .bo (slice_bo)
    );

    // Slices enter from the MSB side so after NSLICE steps slice 0 sits at the LSB.
    assign pdiff_next = {slice_d, pdiff_q[WIDTH-1:DIGIT]};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end
            end
            StRun: begin
                if (cnt_q == CNT_W'(NSLICE - 1)) begin
                    state_d = StDone;
                    last    = 1'b1;
                end
            end
            StDone: begin
                // A request in the done cycle starts the next operation directly.
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge m_clock) begin
        if (!p_reset) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            pdiff_q  <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ov_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_sh_q   <= a;
                b_sh_q   <= b;
                pdiff_q  <= '0;
                cnt_q    <= '0;
                borrow_q <= bin;
                a_msb_q  <= a[WIDTH-1];
                b_msb_q  <= b[WIDTH-1];
            end else if (state_q == StRun) begin
                a_sh_q   <= a_sh_q >> DIGIT;
                b_sh_q   <= b_sh_q >> DIGIT;
                pdiff_q  <= pdiff_next;
                borrow_q <= slice_bo;
                cnt_q    <= cnt_q + 1'b1;
                if (last) begin
                    diff_q <= pdiff_next;
                    bout_q <= slice_bo;
                    ov_q   <= (a_msb_q != b_msb_q) && (pdiff_next[WIDTH-1] != a_msb_q);
                    zero_q <= (pdiff_next == '0);
                end
            end
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ov   = ov_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_sub32_serial.sv
// Directed bench for sub32_serial: vector table plus handshake/reset sequences.
module tb_sub32_serial;

    logic        m_clock = 1'b0;
    logic        p_reset;
    logic        start;
    logic [31:0] a, b;
    logic        bin;
    logic        busy, done;
    logic [31:0] diff;
    logic        bout, ov, zero;

    int total = 0;
    int bad   = 0;

    logic [31:0] prev_diff = '0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bout;
        logic        ov;
        logic        zero;
    } vec_t;

    vec_t vecs [9];

    sub32_serial dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .ov      (ov),
        .zero    (zero)
    );

    always #5 m_clock = ~m_clock;

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [31:0] e_diff, input logic e_bout,
                            input logic e_ov, input logic e_zero);
        chk({name, ".diff"}, diff, e_diff);
        chk({name, ".bout"}, {31'b0, bout}, {31'b0, e_bout});
        chk({name, ".ov"}, {31'b0, ov}, {31'b0, e_ov});
        chk({name, ".zero"}, {31'b0, zero}, {31'b0, e_zero});
    endtask

    // Starts in the current cycle t; returns in cycle t+10 after checking
    // busy over t+1..t+8, done and results at t+9, and hold at t+10.
    task automatic run_vec(input vec_t v, input string name);
        a     = v.a;
        b     = v.b;
        bin   = v.bin;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        bin   = 1'($urandom);
        for (int c = 1; c <= 8; c++) begin
            chk({name, ".busy"}, {31'b0, busy}, 32'd1);
            chk({name, ".nodone"}, {31'b0, done}, 32'd0);
            chk({name, ".hold"}, diff, prev_diff);
            tick();
        end
        chk({name, ".done"}, {31'b0, done}, 32'd1);
        chk({name, ".idle"}, {31'b0, busy}, 32'd0);
        chk_outs(name, v.diff, v.bout, v.ov, v.zero);
        prev_diff = v.diff;
        tick();
        chk({name, ".pulse"}, {31'b0, done}, 32'd0);
        chk({name, ".after"}, diff, v.diff);
    endtask

    initial begin
        vecs[0] = '{32'h0000000A, 32'h00000003, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h00000010, 32'h00000001, 1'b1, 32'h0000000E, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'h00000000, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};

        // Reset with start held high: reset must win.
        p_reset = 1'b0;
        start   = 1'b1;
        a       = 32'h5;
        b       = 32'h1;
        bin     = 1'b0;
        tick();
        tick();
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk_outs("rst", 32'd0, 1'b0, 1'b0, 1'b0);
        start   = 1'b0;
        p_reset = 1'b1;
        tick();
        chk("rst.stay_idle", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulse while busy is ignored; start in the done cycle is accepted.
        a     = 32'h00000100;
        b     = 32'h00000001;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) begin
                a     = 32'h00000050;
                b     = 32'h00000050;
                start = 1'b1;
            end
            chk("hs1.busy", {31'b0, busy}, 32'd1);
            chk("hs1.nodone", {31'b0, done}, 32'd0);
            tick();
            start = 1'b0;
        end
        chk("hs1.done", {31'b0, done}, 32'd1);
        chk_outs("hs1", 32'h000000FF, 1'b0, 1'b0, 1'b0);
        a     = 32'h00000000;
        b     = 32'h00000000;
        bin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 10; c <= 17; c++) begin
            chk("hs2.busy", {31'b0, busy}, 32'd1);
            chk("hs2.hold", diff, 32'h000000FF);
            tick();
        end
        chk("hs2.done", {31'b0, done}, 32'd1);
        chk_outs("hs2", 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        tick();

        // Reset mid-run aborts: no done, outputs cleared.
        a     = 32'h00000009;
        b     = 32'h00000002;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        p_reset = 1'b0;
        tick();
        p_reset = 1'b1;
        chk("abort.busy", {31'b0, busy}, 32'd0);
        chk("abort.done", {31'b0, done}, 32'd0);
        chk_outs("abort", 32'd0, 1'b0, 1'b0, 1'b0);
        prev_diff = 32'd0;
        run_vec('{32'h00000009, 32'h00000002, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0}, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
